// File: rtl/dbus_arbiter.sv
// Two-master / three-slave data-bus arbiter: round-robin grant, address decode,
// illegal-access rejection and one-cycle read-return sequencing.
module dbus_arbiter #(
  parameter logic [31:0] DM_MIN  = 32'h0000_0000,
  parameter logic [31:0] DM_MAX  = 32'h0000_2FFF,
  parameter logic [31:0] TC0_MIN = 32'h0000_7F00,
  parameter logic [31:0] TC0_MAX = 32'h0000_7F0B,
  parameter logic [31:0] TC1_MIN = 32'h0000_7F10,
  parameter logic [31:0] TC1_MAX = 32'h0000_7F1B
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_byteen_i,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_byteen_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        s_dm_sel_o,
  output logic        s_tc0_sel_o,
  output logic        s_tc1_sel_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_byteen_o,
  input  logic [31:0] s_dm_rdata_i,
  input  logic [31:0] s_tc0_rdata_i,
  input  logic [31:0] s_tc1_rdata_i
);

  typedef enum logic {IDLE, RD_WAIT} state_e;

  state_e      state_q;
  logic        rr_last_q;   // 0 = M0 granted last, 1 = M1
  logic        rd_mst_q;
  logic [2:0]  rd_sel_q;    // {tc1, tc0, dm}
  logic        rd_ill_q;

  logic        idle_act, rd_act, gnt0, gnt1, any_gnt, g_mst, g_we;
  logic [31:0] g_addr, g_wdata, tc_off, rd_data;
  logic [3:0]  g_be;
  logic        hit_dm, hit_tc0, hit_tc1, ill, legal;
  logic [2:0]  hit_vec;

  // Offset compare keeps a zero lower bound from producing a constant compare.
  function automatic logic in_rng(input logic [31:0] a, lo, hi);
    return (a - lo) <= (hi - lo);
  endfunction

  always_comb begin
    // Comb outputs are gated by reset so an asserted reset silences the bus at once.
    idle_act = rst_ni && (state_q == IDLE);
    rd_act   = rst_ni && (state_q == RD_WAIT);
    gnt0     = idle_act && m0_req_i && (!m1_req_i || rr_last_q);
    gnt1     = idle_act && m1_req_i && (!m0_req_i || !rr_last_q);
    any_gnt  = gnt0 || gnt1;
    g_mst    = gnt1;
    g_we     = g_mst ? m1_we_i     : m0_we_i;
    g_addr   = g_mst ? m1_addr_i   : m0_addr_i;
    g_wdata  = g_mst ? m1_wdata_i  : m0_wdata_i;
    g_be     = g_mst ? m1_byteen_i : m0_byteen_i;

    hit_dm   = in_rng(g_addr, DM_MIN,  DM_MAX);
    hit_tc0  = in_rng(g_addr, TC0_MIN, TC0_MAX);
    hit_tc1  = in_rng(g_addr, TC1_MIN, TC1_MAX);
    hit_vec  = {hit_tc1, hit_tc0, hit_dm};
    tc_off   = hit_tc1 ? (g_addr - TC1_MIN) : (g_addr - TC0_MIN);

    ill = !(hit_dm || hit_tc0 || hit_tc1)
       || ((hit_tc0 || hit_tc1) && (g_be != 4'b1111))
       || ((hit_tc0 || hit_tc1) && g_we && (tc_off >= 32'd8))
       || (g_be == 4'b0000)
       || ((g_be == 4'b1111) && (g_addr[1:0] != 2'b00));
    legal = any_gnt && !ill;

    {s_tc1_sel_o, s_tc0_sel_o, s_dm_sel_o} = legal ? hit_vec : 3'b000;
    s_we_o     = legal && g_we;
    s_addr_o   = legal ? g_addr  : 32'h0;
    s_wdata_o  = legal ? g_wdata : 32'h0;
    s_byteen_o = legal ? g_be    : 4'h0;

    rd_data = 32'h0;
    if (!rd_ill_q) begin
      unique case (rd_sel_q)
        3'b001:  rd_data = s_dm_rdata_i;
        3'b010:  rd_data = s_tc0_rdata_i;
        3'b100:  rd_data = s_tc1_rdata_i;
        default: rd_data = 32'h0;
      endcase
    end

    m0_gnt_o    = gnt0;
    m1_gnt_o    = gnt1;
    m0_rvalid_o = rd_act && !rd_mst_q;
    m1_rvalid_o = rd_act &&  rd_mst_q;
    m0_rdata_o  = m0_rvalid_o ? rd_data : 32'h0;
    m1_rdata_o  = m1_rvalid_o ? rd_data : 32'h0;
    m0_err_o    = (gnt0 && g_we && ill) || (m0_rvalid_o && rd_ill_q);
    m1_err_o    = (gnt1 && g_we && ill) || (m1_rvalid_o && rd_ill_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      rd_mst_q  <= 1'b0;
      rd_sel_q  <= 3'b000;
      rd_ill_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_gnt) begin
            rr_last_q <= g_mst;
            if (!g_we) begin
              rd_mst_q <= g_mst;
              rd_sel_q <= ill ? 3'b000 : hit_vec;
              rd_ill_q <= ill;
              state_q  <= RD_WAIT;
            end
          end
        end
        RD_WAIT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: inputs change on the falling edge, outputs
// are checked 1 ns later, state advances on the rising edge.
module tb_dbus_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dm_sel, tc0_sel, tc1_sel, s_we;
  logic [31:0] s_addr, s_wdata, dm_rd, tc0_rd, tc1_rd;
  logic [3:0]  s_be;
  int          n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  dbus_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_byteen_i(m0_be),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_byteen_i(m1_be),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .s_dm_sel_o(dm_sel), .s_tc0_sel_o(tc0_sel), .s_tc1_sel_o(tc1_sel), .s_we_o(s_we),
    .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_byteen_o(s_be),
    .s_dm_rdata_i(dm_rd), .s_tc0_rdata_i(tc0_rd), .s_tc1_rdata_i(tc1_rd));

  wire [2:0] sel = {tc1_sel, tc0_sel, dm_sel};
  wire [1:0] gnt = {m1_gnt, m0_gnt};
  wire [1:0] rv  = {m1_rvalid, m0_rvalid};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv0(input logic req, we, input logic [31:0] a, d, input logic [3:0] be);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; m0_be = be;
  endtask

  task automatic drv1(input logic req, we, input logic [31:0] a, d, input logic [3:0] be);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_be = be;
  endtask

  // Advance to the next falling edge with both masters quiet.
  task automatic step;
    @(negedge clk);
    drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0);
  endtask

  initial begin
    drv0(1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF); drv1(1, 0, 32'h7F04, 0, 4'hF);
    dm_rd = 32'hCAFE_0001; tc0_rd = 32'h0000_00A5; tc1_rd = 32'h5A5A_0002;

    // Reset: requests present but everything must stay silent.
    #2;
    chk("rst_gnt", gnt, 0);       chk("rst_rvalid", rv, 0);
    chk("rst_sel", sel, 0);       chk("rst_swe", s_we, 0);
    chk("rst_saddr", s_addr, 0);  chk("rst_swdata", s_wdata, 0);
    chk("rst_sbe", s_be, 0);      chk("rst_err", {m1_err, m0_err}, 0);
    chk("rst_rdata", m0_rdata | m1_rdata, 0);
    step(); rst_n = 1'b1;

    // Tie on back-to-back writes: M0 first, then strict alternation.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drv0(1, 1, 32'h0, 32'h1111_0000, 4'hF); drv1(1, 1, 32'h4, 32'h2222_0000, 4'hF);
      #1 chk($sformatf("tie_gnt%0d", i), gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("tie_saddr%0d", i), s_addr, (i % 2 == 0) ? 32'h0 : 32'h4);
    end

    // Lone M0 word store to DM.
    step(); drv0(1, 1, 32'h10, 32'h1234_5678, 4'hF);
    #1 chk("sw_gnt", gnt, 2'b01); chk("sw_sel", sel, 3'b001); chk("sw_swe", s_we, 1);
    chk("sw_err", m0_err, 0); chk("sw_saddr", s_addr, 32'h10); chk("sw_swdata", s_wdata, 32'h1234_5678);
    chk("sw_sbe", s_be, 4'hF);

    // M1 read of TC0; M0 arrives during RD_WAIT and must wait a cycle.
    step(); drv1(1, 0, 32'h7F04, 0, 4'hF);
    #1 chk("rd_gnt", gnt, 2'b10); chk("rd_sel", sel, 3'b010); chk("rd_swe", s_we, 0);
    chk("rd_rv_early", rv, 0);
    step(); drv0(1, 1, 32'h20, 32'h0BAD_F00D, 4'hF);
    #1 chk("rd_rv", rv, 2'b10); chk("rd_rdata", m1_rdata, 32'h0000_00A5); chk("rd_err", m1_err, 0);
    chk("rd_m0rdata", m0_rdata, 0); chk("rd_wait_gnt", gnt, 0); chk("rd_wait_sel", sel, 0);
    @(negedge clk);
    #1 chk("rd_next_gnt", gnt, 2'b01); chk("rd_next_rv", rv, 0);

    // TC1 top word read (legal) and its data return.
    step(); drv0(1, 0, 32'h7F18, 0, 4'hF);
    #1 chk("tc1_sel", sel, 3'b100);
    step(); #1 chk("tc1_rdata", m0_rdata, 32'h5A5A_0002); chk("tc1_err", m0_err, 0);

    // Rejected writes: byte to timer count, word to timer count, word past DM, zero byteen.
    step(); drv0(1, 1, 32'h7F08, 32'hFF, 4'b0001);
    #1 chk("sb_tc_gnt", gnt, 2'b01); chk("sb_tc_err", m0_err, 1); chk("sb_tc_sel", sel, 0); chk("sb_tc_swe", s_we, 0);
    step(); drv0(1, 1, 32'h7F08, 32'h1, 4'hF);
    #1 chk("sw_tcro_err", m0_err, 1); chk("sw_tcro_sel", sel, 0);
    step(); drv1(1, 1, 32'h3000, 32'h1, 4'hF);
    #1 chk("sw_3000_gnt", gnt, 2'b10); chk("sw_3000_err", m1_err, 1); chk("sw_3000_sel", sel, 0);
    chk("sw_3000_swe", s_we, 0); chk("sw_3000_saddr", s_addr, 0);
    step(); drv0(1, 1, 32'h40, 32'h1, 4'h0);
    #1 chk("be0_err", m0_err, 1);

    // Top DM byte is legal.
    step(); drv0(1, 1, 32'h2FFF, 32'h7700_0000, 4'b1000);
    #1 chk("dm_top_err", m0_err, 0); chk("dm_top_sel", sel, 3'b001);

    // Illegal read: error reported with rvalid, data forced to zero.
    step(); drv0(1, 0, 32'h3000, 0, 4'hF);
    #1 chk("rd3000_gnt", gnt, 2'b01); chk("rd3000_gerr", m0_err, 0); chk("rd3000_sel", sel, 0);
    step(); #1 chk("rd3000_rv", rv, 2'b01); chk("rd3000_err", m0_err, 1); chk("rd3000_rdata", m0_rdata, 0);

    // Alignment: misaligned word rejected, upper halfword accepted.
    step(); drv0(1, 1, 32'h2, 32'h1, 4'hF);
    #1 chk("mis_err", m0_err, 1); chk("mis_sel", sel, 0);
    step(); drv0(1, 1, 32'h2, 32'hABCD_0000, 4'b1100);
    #1 chk("sh_err", m0_err, 0); chk("sh_sbe", s_be, 4'b1100); chk("sh_sel", sel, 3'b001);

    // Reset during RD_WAIT: response dropped, arbiter back to M0 priority.
    step(); drv1(1, 0, 32'h100, 0, 4'hF);
    #1 chk("rrd_gnt", gnt, 2'b10);
    step(); rst_n = 1'b0;
    #1 chk("rrd_rv", rv, 0); chk("rrd_rdata", m1_rdata, 0); chk("rrd_err", m1_err, 0);
    step(); rst_n = 1'b1;
    #1 chk("rrd_after_rv", rv, 0);
    @(negedge clk);
    drv0(1, 1, 32'h8, 32'h1, 4'hF); drv1(1, 1, 32'hC, 32'h2, 4'hF);
    #1 chk("rrd_tie", gnt, 2'b01); chk("rrd_tie_rv", rv, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-master, three-slave data-bus arbiter and sequencer.
- Masters: M0 is the CPU MEM-stage data port, which drives byte-enables and store data already aligned by the store-alignment logic. M1 is the debug/DMA port.
- Slaves: data memory (DM), timer TC0, timer TC1.
- The block arbitrates round-robin, decodes addresses, rejects illegal accesses, and sequences the one-cycle read-return of the slaves.

Parameters:
- DM_MIN, 32'h0000_0000, lowest DM byte address
- DM_MAX, 32'h0000_2FFF, highest DM byte address
- TC0_MIN, 32'h0000_7F00, TC0 base
- TC0_MAX, 32'h0000_7F0B, TC0 top
- TC1_MIN, 32'h0000_7F10, TC1 base
- TC1_MAX, 32'h0000_7F1B, TC1 top

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1  request, held until grant
- m0_we, m1_we  in  1  1=write, 0=read
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  lane-aligned write data
- m0_byteen, m1_byteen  in  4  byte enables; 4'b1111 for word
- m0_gnt, m1_gnt  out  1  1-cycle pulse, transaction accepted
- m0_rvalid, m1_rvalid  out  1  read data/err valid, 1 cycle
- m0_rdata, m1_rdata  out  32  read data
- m0_err, m1_err  out  1  access rejected; writes: with gnt, reads: with rvalid
- s_dm_sel, s_tc0_sel, s_tc1_sel  out  1  slave select, one-hot or zero
- s_we  out  1  slave write strobe
- s_addr  out  32  granted address
- s_wdata  out  32  granted write data
- s_byteen  out  4  granted byte enables
- s_dm_rdata, s_tc0_rdata, s_tc1_rdata  in  32  slave read data, valid the cycle after select

Behaviour:
- Reset state: FSM=IDLE, rr_last=1 (M0 wins first tie).
- Reset outputs: all gnt/rvalid/err/sel/s_we = 0; s_addr, s_wdata, s_byteen, rdata = 0.
- Reset asserted mid-read drops the pending rvalid; no late response is issued.
- FSM states:
  - IDLE: accept new transactions.
  - RD_WAIT: one cycle, returns read data.
- Arbitration in IDLE (combinational):
  - Exactly one requester: grant it.
  - Both requesting: grant the master != rr_last.
  - rr_last updates to the granted master on each grant.
  - RD_WAIT grants nobody.
- Decode of the granted address:
  - hit_dm = DM_MIN <= addr <= DM_MAX; hit_tc0 and hit_tc1 are defined likewise.
  - ill (illegal) is true for any of:
    - no hit;
    - timer hit with byteen != 4'b1111;
    - write to timer offset 8..B (count register is read-only);
    - byteen == 0;
    - word access with addr[1:0] != 0.
- Legal grant: assert the selected s_*_sel and copy addr, wdata and byteen to the slave side that same cycle; s_we = we.
- Illegal grant: no sel and s_we = 0.
- Write grant:
  - gnt = 1, err = ill in the same cycle.
  - Stay IDLE; back-to-back writes at one per cycle are allowed.
- Read grant:
  - gnt = 1; register the master id, slave id and ill; go to RD_WAIT.
  - In RD_WAIT: that master's rvalid = 1 and err = ill_q.
  - rdata = the selected s_*_rdata, or 0 if ill_q.
  - Next state is IDLE.
- The non-granted master's outputs remain 0.
- Read latency: gnt at cycle N, rvalid at N+1. The earliest next grant is N+2.
- A req dropped before its grant is ignored; no state change.

Test Plan:
- Lone M0 sw: addr 0x0000_0010, wdata 0x1234_5678, byteen 1111 -> same cycle m0_gnt=1, s_dm_sel=1, s_we=1, m0_err=0.
- Both request continuously after reset (writes) -> grants alternate M0, M1, M0, M1, one per cycle.
- M1 read 0x0000_7F04 with s_tc0_rdata=0xA5 -> gnt cycle N; cycle N+1 m1_rvalid=1, m1_rdata=0x0000_00A5; M0 request in cycle N+1 is not granted until N+2.
- Rejected writes: M0 sb to 0x0000_7F08; M0 sw to 0x0000_3000 -> gnt=1, err=1, no sel, s_we=0; for a read of 0x3000 -> rvalid=1, err=1, rdata=0.
- Misaligned sw to 0x0000_0002 -> err=1; sh with byteen 1100 to 0x0000_0002 -> err=0, s_byteen=1100.
- Pull reset low during RD_WAIT -> all outputs 0 immediately; no rvalid after release; first tie after release is granted to M0.
